// File: rtl/width_pack_arb.sv
// ============================================================================
// width_pack_arb : 4-way round-robin arbiter feeding 16-beat frames of 24-bit
//                  beats into a 24-to-128 packer. Optional macro ARB_TIMEOUT_EN
//                  pads a stalled frame with zero beats after TIMEOUT cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module width_pack_arb #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  req_valid,
    input  logic [95:0] req_data,
    output logic [3:0]  req_ready,
    output logic        pk_validin,
    output logic [23:0] pk_datain,
    output logic [1:0]  grant_id,
    output logic        frame_done,
    output logic        busy,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1
`ifdef ARB_TIMEOUT_EN
        , PAD = 2'd2
`endif
    } state_t;

    state_t      r_state;
    logic [3:0]  r_beat_cnt;
    logic [1:0]  r_last_grant;
    logic [1:0]  w_rr_pick;
    logic [1:0]  w_rr_idx;
    logic        w_rr_hit;
    logic        w_xfer;
    logic [23:0] w_owner_data;
`ifdef ARB_TIMEOUT_EN
    logic [7:0]  r_idle_cnt;
`endif

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range_check
        $error("width_pack_arb: TIMEOUT must be within 1..255");
    end

    // Search starts one past the previous owner; k==4 wraps back to it last.
    always_comb begin
        w_rr_pick = r_last_grant;
        w_rr_idx  = r_last_grant;
        w_rr_hit  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_rr_idx = r_last_grant + 2'(k);
            if (!w_rr_hit && req_valid[w_rr_idx]) begin
                w_rr_hit  = 1'b1;
                w_rr_pick = w_rr_idx;
            end
        end
    end

    assign w_xfer       = (r_state == GRANT) && req_valid[grant_id];
    assign w_owner_data = req_data[24*grant_id +: 24];
    assign req_ready    = (r_state == GRANT) ? (4'b0001 << grant_id) : 4'b0000;
    assign busy         = (r_state != IDLE);

`ifndef ARB_TIMEOUT_EN
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_beat_cnt   <= 4'd0;
            r_last_grant <= 2'd3;
            pk_validin   <= 1'b0;
            pk_datain    <= 24'd0;
            grant_id     <= 2'd0;
            frame_done   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err_timeout  <= 1'b0;
            r_idle_cnt   <= 8'd0;
`endif
        end else begin
            pk_validin  <= 1'b0;
            frame_done  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_rr_hit) begin
                        grant_id <= w_rr_pick;
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_xfer) begin
                        pk_validin <= 1'b1;
                        pk_datain  <= w_owner_data;
                        r_beat_cnt <= r_beat_cnt + 4'd1;
`ifdef ARB_TIMEOUT_EN
                        r_idle_cnt <= 8'd0;
`endif
                        if (r_beat_cnt == 4'd15) begin
                            r_state      <= IDLE;
                            r_last_grant <= grant_id;
                            frame_done   <= 1'b1;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_idle_cnt == 8'(TIMEOUT - 1)) begin
                        r_idle_cnt  <= 8'd0;
                        r_state     <= PAD;
                        err_timeout <= 1'b1;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 8'd1;
                    end
`endif
                end
`ifdef ARB_TIMEOUT_EN
                // Zero beats complete the frame so the packer phase stays aligned.
                PAD: begin
                    pk_validin <= 1'b1;
                    pk_datain  <= 24'd0;
                    r_beat_cnt <= r_beat_cnt + 4'd1;
                    if (r_beat_cnt == 4'd15) begin
                        r_state      <= IDLE;
                        r_last_grant <= grant_id;
                        frame_done   <= 1'b1;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_width_pack_arb.sv
// Testbench for width_pack_arb: directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
`default_nettype none

module tb_width_pack_arb;

    localparam int TB_TIMEOUT = 6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  req_valid = 4'd0;
    logic [95:0] req_data = 96'd0;
    logic [3:0]  req_ready;
    logic        pk_validin;
    logic [23:0] pk_datain;
    logic [1:0]  grant_id;
    logic        frame_done;
    logic        busy;
    logic        err_timeout;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int seq [4];

    width_pack_arb #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .pk_validin (pk_validin),
        .pk_datain  (pk_datain),
        .grant_id   (grant_id),
        .frame_done (frame_done),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Requester i presents {i, 0, sequence number} on its lane.
    task automatic update_data();
        for (int i = 0; i < 4; i++)
            req_data[24*i +: 24] = {4'(i), 4'h0, 16'(seq[i])};
    endtask

    task automatic tick();
        logic [3:0] x;
        x = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (x[i]) seq[i]++;
        update_data();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = 4'd0;
        for (int i = 0; i < 4; i++) seq[i] = 1;
        update_data();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) seq[i] = 1;
        update_data();
        @(posedge clk);
        @(posedge clk);
        #1;
        total_cnt++; if (req_ready !== 4'h0) $display("FAIL reset_ready: got %b want 0000", req_ready); else pass_cnt++;
        total_cnt++; if (pk_validin !== 1'b0) $display("FAIL reset_pkvalid: got %b want 0", pk_validin); else pass_cnt++;
        total_cnt++; if (pk_datain !== 24'd0) $display("FAIL reset_pkdata: got %h want 0", pk_datain); else pass_cnt++;
        total_cnt++; if (grant_id !== 2'd0) $display("FAIL reset_grant: got %0d want 0", grant_id); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_done: got %b want 0", frame_done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (err_timeout !== 1'b0) $display("FAIL reset_err: got %b want 0", err_timeout); else pass_cnt++;
        req_valid = 4'h0;
        rstn = 1'b1;
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        tick();
        total_cnt++; if (grant_id !== 2'd0) $display("FAIL single_grant: got %0d want 0", grant_id); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (pk_validin !== 1'b0) $display("FAIL single_nolat: got %b want 0", pk_validin); else pass_cnt++;
        for (int k = 1; k <= 16; k++) begin
            tick();
            total_cnt++; if (pk_validin !== 1'b1) $display("FAIL single_valid%0d: got %b want 1", k, pk_validin); else pass_cnt++;
            total_cnt++; if (pk_datain !== 24'(k)) $display("FAIL single_data%0d: got %h want %h", k, pk_datain, 24'(k)); else pass_cnt++;
            total_cnt++; if (frame_done !== (k == 16)) $display("FAIL single_done%0d: got %b want %b", k, frame_done, (k == 16)); else pass_cnt++;
        end
        req_valid = 4'b0000;
        total_cnt++; if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL single_stay_idle: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (pk_validin !== 1'b0) $display("FAIL single_novalid: got %b want 0", pk_validin); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'hF;
        for (int f = 0; f < 5; f++) begin
            int o;
            logic [23:0] exp;
            o = f % 4;
            tick();
            total_cnt++; if (grant_id !== 2'(o)) $display("FAIL rr_grant%0d: got %0d want %0d", f, grant_id, o); else pass_cnt++;
            total_cnt++; if (pk_validin !== 1'b0) $display("FAIL rr_arb_cycle%0d: got %b want 0", f, pk_validin); else pass_cnt++;
            for (int k = 1; k <= 16; k++) begin
                tick();
                exp = {4'(o), 4'h0, 16'(16 * (f / 4) + k)};
                total_cnt++; if (pk_datain !== exp || pk_validin !== 1'b1)
                    $display("FAIL rr_data f%0d k%0d: got %b/%h want 1/%h", f, k, pk_validin, pk_datain, exp); else pass_cnt++;
                total_cnt++; if (req_ready !== ((k == 16) ? 4'h0 : 4'(1 << o)))
                    $display("FAIL rr_ready f%0d k%0d: got %b want one-hot %0d", f, k, req_ready, o); else pass_cnt++;
                total_cnt++; if (frame_done !== (k == 16)) $display("FAIL rr_done f%0d k%0d: got %b", f, k, frame_done); else pass_cnt++;
            end
            total_cnt++; if (busy !== 1'b0) $display("FAIL rr_gap%0d: got busy %b want 0", f, busy); else pass_cnt++;
        end
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_no_preempt();
        do_reset();
        req_valid = 4'b0010;
        tick();
        for (int k = 1; k <= 16; k++) tick();
        total_cnt++; if (frame_done !== 1'b1) $display("FAIL np_first_done: got %b want 1", frame_done); else pass_cnt++;
        req_valid = 4'b0110;
        tick();
        total_cnt++; if (grant_id !== 2'd2) $display("FAIL np_grant2: got %0d want 2", grant_id); else pass_cnt++;
        for (int k = 1; k <= 7; k++) tick();
        total_cnt++; if (pk_datain !== 24'h200007) $display("FAIL np_beat7: got %h want 200007", pk_datain); else pass_cnt++;
        req_valid[2] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            total_cnt++; if (pk_validin !== 1'b0 || grant_id !== 2'd2 || req_ready !== 4'b0100)
                $display("FAIL np_stall%0d: got v%b g%0d r%b want v0 g2 r0100", c, pk_validin, grant_id, req_ready); else pass_cnt++;
        end
        req_valid[2] = 1'b1;
        for (int k = 8; k <= 16; k++) begin
            tick();
            total_cnt++; if (pk_validin !== 1'b1 || pk_datain !== {4'd2, 4'h0, 16'(k)})
                $display("FAIL np_beat%0d: got %b/%h want 1/%h", k, pk_validin, pk_datain, {4'd2, 4'h0, 16'(k)}); else pass_cnt++;
        end
        total_cnt++; if (frame_done !== 1'b1) $display("FAIL np_done: got %b want 1", frame_done); else pass_cnt++;
        req_valid = 4'b0010;
        tick();
        total_cnt++; if (grant_id !== 2'd1) $display("FAIL np_next_owner: got %0d want 1", grant_id); else pass_cnt++;
        req_valid = 4'b0000;
    endtask

    task automatic test_timeout();
        do_reset();
        req_valid = 4'b0001;
        tick();
        for (int k = 1; k <= 10; k++) tick();
        total_cnt++; if (pk_datain !== 24'd10) $display("FAIL to_beat10: got %h want 00000a", pk_datain); else pass_cnt++;
        req_valid = 4'b0000;
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= TB_TIMEOUT; c++) begin
            tick();
            total_cnt++; if (err_timeout !== (c == TB_TIMEOUT) || pk_validin !== 1'b0)
                $display("FAIL to_wait%0d: got err %b v %b want err %b v 0", c, err_timeout, pk_validin, (c == TB_TIMEOUT)); else pass_cnt++;
        end
        total_cnt++; if (req_ready !== 4'h0) $display("FAIL to_pad_ready: got %b want 0000", req_ready); else pass_cnt++;
        for (int p = 1; p <= 6; p++) begin
            tick();
            total_cnt++; if (pk_validin !== 1'b1 || pk_datain !== 24'd0 || err_timeout !== 1'b0)
                $display("FAIL to_pad%0d: got v%b d%h e%b want v1 d0 e0", p, pk_validin, pk_datain, err_timeout); else pass_cnt++;
            total_cnt++; if (frame_done !== (p == 6)) $display("FAIL to_pad_done%0d: got %b", p, frame_done); else pass_cnt++;
        end
`else
        for (int c = 1; c <= 20; c++) begin
            tick();
            total_cnt++; if (err_timeout !== 1'b0 || pk_validin !== 1'b0 || busy !== 1'b1)
                $display("FAIL to_wait%0d: got err %b v %b busy %b want 0 0 1", c, err_timeout, pk_validin, busy); else pass_cnt++;
        end
        req_valid = 4'b0001;
        for (int k = 11; k <= 16; k++) begin
            tick();
            total_cnt++; if (pk_validin !== 1'b1 || pk_datain !== 24'(k))
                $display("FAIL to_resume%0d: got %b/%h want 1/%h", k, pk_validin, pk_datain, 24'(k)); else pass_cnt++;
            total_cnt++; if (frame_done !== (k == 16)) $display("FAIL to_resume_done%0d: got %b", k, frame_done); else pass_cnt++;
        end
        req_valid = 4'b0000;
`endif
        total_cnt++; if (busy !== 1'b0) $display("FAIL to_end_idle: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        req_valid = 4'b0010;
        tick();
        for (int k = 1; k <= 9; k++) tick();
        rstn = 1'b0;
        #1;
        total_cnt++; if (pk_validin !== 1'b0 || pk_datain !== 24'd0 || grant_id !== 2'd0)
            $display("FAIL mr_outputs: got v%b d%h g%0d want 0 0 0", pk_validin, pk_datain, grant_id); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || req_ready !== 4'h0 || frame_done !== 1'b0 || err_timeout !== 1'b0)
            $display("FAIL mr_status: got busy%b r%b fd%b e%b want all 0", busy, req_ready, frame_done, err_timeout); else pass_cnt++;
        req_valid = 4'b0011;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        total_cnt++; if (grant_id !== 2'd0) $display("FAIL mr_grant: got %0d want 0", grant_id); else pass_cnt++;
        for (int k = 1; k <= 16; k++) begin
            tick();
            total_cnt++; if (pk_validin !== 1'b1 || pk_datain !== 24'(k) || frame_done !== (k == 16))
                $display("FAIL mr_beat%0d: got v%b d%h fd%b want 1 %h %b", k, pk_validin, pk_datain, frame_done, 24'(k), (k == 16)); else pass_cnt++;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_packer();
        int bits, words, frames, nbeat, cyc, tag_bad;
        int exp_owner [3];
        logic [3:0] cur_tag;
        exp_owner[0] = 1; exp_owner[1] = 3; exp_owner[2] = 1;
        bits = 0; words = 0; frames = 0; nbeat = 0; cyc = 0; tag_bad = 0;
        cur_tag = 4'd0;
        do_reset();
        req_valid = 4'b1010;
        while (frames < 3 && cyc < 300) begin
            req_valid[3] = !(busy && grant_id == 2'd3 && (cyc % 3) == 0);
            tick();
            cyc++;
            if (pk_validin) begin
                if (nbeat == 0) cur_tag = pk_datain[23:20];
                else if (pk_datain[23:20] != cur_tag) tag_bad++;
                nbeat++;
                bits += 24;
                if (bits >= 128) begin
                    words++;
                    bits -= 128;
                end
                if (frame_done) begin
                    total_cnt++; if (cur_tag !== 4'(exp_owner[frames]))
                        $display("FAIL pk_owner%0d: got %0d want %0d", frames, cur_tag, exp_owner[frames]); else pass_cnt++;
                    total_cnt++; if (nbeat != 16 || words != 3 * (frames + 1))
                        $display("FAIL pk_frame%0d: got beats %0d words %0d want 16 %0d", frames, nbeat, words, 3 * (frames + 1)); else pass_cnt++;
                    frames++;
                    nbeat = 0;
                end
            end
        end
        req_valid = 4'b0000;
        total_cnt++; if (frames != 3) $display("FAIL pk_frames: got %0d want 3 within cycle budget", frames); else pass_cnt++;
        total_cnt++; if (words != 9 || bits != 0) $display("FAIL pk_words: got %0d words %0d spare bits want 9 0", words, bits); else pass_cnt++;
        total_cnt++; if (tag_bad != 0) $display("FAIL pk_purity: got %0d foreign beats want 0", tag_bad); else pass_cnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_no_preempt();
        test_timeout();
        test_reset_midframe();
        test_packer();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
